// File: rtl/uart_rx_byte_fifo_if.sv
// rtl/uart_rx_byte_fifo_if.sv - Handshake/status bundle between the UART receiver, the byte FIFO and its consumer

interface uart_rx_byte_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);

  // Producer side: byte strobe from the UART receiver
  logic [7:0]          rx_data;
  logic                rx_data_valid;

  // Consumer side: pop request and sticky-flag clear
  logic                rd_en;
  logic                clear_overflow;

  // FIFO status and head byte
  logic [7:0]          rd_data;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                almost_full;

  // Environment view: drives bytes and pops, observes status
  modport master (
    output rx_data,
    output rx_data_valid,
    output rd_en,
    output clear_overflow,
    input  rd_data,
    input  empty,
    input  full,
    input  count,
    input  overflow,
    input  almost_full
  );

  // FIFO view
  modport slave (
    input  rx_data,
    input  rx_data_valid,
    input  rd_en,
    input  clear_overflow,
    output rd_data,
    output empty,
    output full,
    output count,
    output overflow,
    output almost_full
  );

endinterface

// File: rtl/uart_rx_byte_fifo.sv
// rtl/uart_rx_byte_fifo.sv - Circular byte FIFO behind the UART receiver with sticky overflow; optional almost_full via UART_RX_FIFO_ALMOST_FULL_EN

module uart_rx_byte_fifo #(
  parameter int DEPTH_LOG2         = 4,
  parameter int ALMOST_FULL_THRESH = 12
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  uart_rx_byte_fifo_if.slave     bus
);

  localparam int                  LP_DEPTH_INT = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LP_DEPTH     = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LP_CNT_ZERO  = '0;
  localparam logic [DEPTH_LOG2:0] LP_CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] LP_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  // A threshold outside 1..depth would make almost_full meaningless; stop elaboration instead
  if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > LP_DEPTH_INT) begin : g_bad_thresh
    $error("uart_rx_byte_fifo: ALMOST_FULL_THRESH out of range");
  end

  // Storage and control state; the array itself is never reset
  logic [7:0]            r_mem [LP_DEPTH_INT];
  logic [DEPTH_LOG2-1:0] r_wp;
  logic [DEPTH_LOG2-1:0] r_rp;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_rd_accept;
  logic                  w_wr_accept;
  logic                  w_drop;
  logic [DEPTH_LOG2:0]   w_count_next;

  // Flags come straight from the registered occupancy so they never glitch on inputs
  assign w_empty = (r_count == LP_CNT_ZERO);
  assign w_full  = (r_count == LP_DEPTH);

  // A pop on an empty FIFO is a no-op; a write into a full FIFO only succeeds if a pop frees the slot
  assign w_rd_accept = bus.rd_en & ~w_empty;
  assign w_wr_accept = bus.rx_data_valid & (~w_full | w_rd_accept);
  assign w_drop      = bus.rx_data_valid & w_full & ~bus.rd_en;

  // Next occupancy: simultaneous accept of write and read leaves it unchanged
  always_comb begin
    w_count_next = r_count;
    case ({w_wr_accept, w_rd_accept})
      2'b10:   w_count_next = r_count + LP_CNT_ONE;
      2'b01:   w_count_next = r_count - LP_CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Byte storage: written only when the write is accepted
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_wr_accept) begin
      r_mem[r_wp] <= bus.rx_data;
    end
  end

  // Pointers and occupancy counter; pointers wrap naturally at the depth boundary
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_accept) begin
        r_wp <= r_wp + LP_PTR_ONE;
      end
      if (w_rd_accept) begin
        r_rp <= r_rp + LP_PTR_ONE;
      end
      r_count <= w_count_next;
    end
  end

  // Sticky lost-byte flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  localparam logic [DEPTH_LOG2:0] LP_AF_THRESH = ALMOST_FULL_THRESH[DEPTH_LOG2:0];

  logic r_almost_full;

  // Flow-control hint toward the link, computed from the next count so it tracks count on the same edge
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_count_next >= LP_AF_THRESH);
    end
  end

  assign bus.almost_full = r_almost_full;
`else
  assign bus.almost_full = 1'b0;
`endif

  // First-word fall-through head; reads as zero when nothing is stored
  assign bus.rd_data  = w_empty ? 8'h00 : r_mem[r_rp];
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// tb/tb_uart_rx_byte_fifo.sv - Scoreboard bench for uart_rx_byte_fifo (honours UART_RX_FIFO_ALMOST_FULL_EN)

`timescale 1ns/1ps

module tb_uart_rx_byte_fifo;

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic clk;
  logic reset;

  uart_rx_byte_fifo_if #(.DEPTH_LOG2(4)) bus ();

  uart_rx_byte_fifo #(
    .DEPTH_LOG2         (4),
    .ALMOST_FULL_THRESH (12)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb [$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must present the oldest expected byte
  always @(negedge clk) begin
    if (!reset && bus.rd_en && !bus.empty) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no byte", bus.rd_data);
      end else begin
        chk("pop_data", int'(bus.rd_data), int'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit accepted);
    bus.rx_data       = b;
    bus.rx_data_valid = 1'b1;
    if (accepted) sb.push_back(b);
    tick();
    bus.rx_data_valid = 1'b0;
  endtask

  task automatic pop(input int n);
    bus.rd_en = 1'b1;
    repeat (n) tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_empty"},    int'(bus.empty),    1);
    chk({tag, "_count"},    int'(bus.count),    0);
    chk({tag, "_rd_data"},  int'(bus.rd_data),  0);
    chk({tag, "_full"},     int'(bus.full),     0);
    chk({tag, "_af"},       int'(bus.almost_full), 0);
  endtask

  initial begin
    reset                 = 1'b1;
    bus.rx_data           = 8'h00;
    bus.rx_data_valid     = 1'b0;
    bus.rd_en             = 1'b0;
    bus.clear_overflow    = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state, then pops on an empty FIFO change nothing
    chk_idle("reset");
    chk("reset_overflow", int'(bus.overflow), 0);
    bus.rd_en = 1'b1;
    repeat (3) tick();
    bus.rd_en = 1'b0;
    chk_idle("empty_pop");

    // Three spaced bytes, then pop in order
    push(8'hA5, 1'b1);
    repeat (9) tick();
    push(8'h3C, 1'b1);
    repeat (9) tick();
    push(8'hFF, 1'b1);
    chk("three_count", int'(bus.count), 3);
    chk("three_head",  int'(bus.rd_data), 8'hA5);
    pop(3);
    chk("three_drained_empty", int'(bus.empty), 1);
    chk("three_drained_data",  int'(bus.rd_data), 0);

    // Fill to 16, drop one, drain, clear sticky overflow
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    chk("fill_full",  int'(bus.full),  1);
    chk("fill_count", int'(bus.count), 16);
    chk("fill_ovf",   int'(bus.overflow), 0);
    push(8'h55, 1'b0);
    chk("drop_ovf",   int'(bus.overflow), 1);
    chk("drop_count", int'(bus.count), 16);
    pop(16);
    chk("drop_drained_empty", int'(bus.empty), 1);
    chk("drop_ovf_sticky",    int'(bus.overflow), 1);
    bus.clear_overflow = 1'b1;
    tick();
    bus.clear_overflow = 1'b0;
    chk("clear_ovf", int'(bus.overflow), 0);

    // Full FIFO with simultaneous write and pop
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1'b1);
    bus.rx_data       = 8'h77;
    bus.rx_data_valid = 1'b1;
    bus.rd_en         = 1'b1;
    sb.push_back(8'h77);
    tick();
    bus.rx_data_valid = 1'b0;
    bus.rd_en         = 1'b0;
    chk("full_rw_count", int'(bus.count), 16);
    chk("full_rw_ovf",   int'(bus.overflow), 0);
    pop(16);
    chk("full_rw_empty", int'(bus.empty), 1);

    // Pointer wrap
    for (int i = 0; i < 10; i++) push(8'h40 + 8'(i), 1'b1);
    pop(10);
    for (int i = 0; i < 10; i++) push(8'h80 + 8'(i), 1'b1);
    chk("wrap_count", int'(bus.count), 10);
    chk("wrap_head",  int'(bus.rd_data), 8'h80);
    pop(10);
    chk("wrap_empty", int'(bus.empty), 1);

    // Reset mid-stream discards contents
    for (int i = 0; i < 5; i++) push(8'h90 + 8'(i), 1'b1);
    chk("pre_reset_count", int'(bus.count), 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    chk_idle("mid_reset");

    // Almost-full threshold at 12
    for (int i = 0; i < 11; i++) push(8'hC0 + 8'(i), 1'b1);
    chk("af_11_count", int'(bus.count), 11);
    chk("af_11",       int'(bus.almost_full), 0);
    push(8'hCB, 1'b1);
    chk("af_12_count", int'(bus.count), 12);
    chk("af_12",       int'(bus.almost_full), AF_EN ? 1 : 0);
    pop(1);
    chk("af_pop_count", int'(bus.count), 11);
    chk("af_pop",       int'(bus.almost_full), 0);
    pop(11);
    chk("final_empty", int'(bus.empty), 1);
    chk("sb_leftover", sb.size(), 0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
